// File: rtl/serial_addsub_digit.sv
// Digit-serial two's-complement adder/subtractor, LSB digit first, DIGIT_W bits per beat.
// Latency: 1 cycle from accepted beat to registered result digit.
// Backpressure: none; every in_valid beat is accepted. Optional out_zero via SERIAL_ADDSUB_ZERO_FLAG_EN.
module serial_addsub_digit #(
  parameter int DIGIT_W     = 1,
  parameter int WORD_DIGITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               sub,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               out_valid,
  output logic [DIGIT_W-1:0] out_sum,
  output logic               out_last,
  output logic               out_carry,
  output logic               out_ovf
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
  ,
  output logic               out_zero
`endif
);

  localparam int CNT_W = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_DIGITS - 1);

  // Word-level state
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               mode_q, mode_d;

  // Registered outputs
  logic               out_valid_q, out_valid_d;
  logic [DIGIT_W-1:0] out_sum_q, out_sum_d;
  logic               out_last_q, out_last_d;
  logic               out_carry_q, out_carry_d;
  logic               out_ovf_q, out_ovf_d;

  // Datapath nets
  logic               first_beat;
  logic               last_beat;
  logic               m_eff;
  logic [DIGIT_W-1:0] b_eff;
  logic [DIGIT_W-1:0] s;
  logic [DIGIT_W:0]   c;

`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
  logic               nz_q, nz_d;
  logic               nz_next;
  logic               out_zero_q, out_zero_d;
`endif

  // Digit ripple chain; the first beat of a word takes mode and carry-in straight from sub
  always_comb begin
    first_beat = (cnt_q == '0);
    last_beat  = in_valid & (cnt_q == LAST_IDX);
    m_eff      = first_beat ? sub : mode_q;
    b_eff      = b ^ {DIGIT_W{m_eff}};
    s          = '0;
    c          = '0;
    c[0]       = first_beat ? sub : carry_q;
    for (int i = 0; i < DIGIT_W; i++) begin
      s[i]   = a[i] ^ b_eff[i] ^ c[i];
      c[i+1] = (a[i] & b_eff[i]) | (a[i] & c[i]) | (b_eff[i] & c[i]);
    end
  end

  // Next-state for word state and registered outputs
  always_comb begin
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    mode_d      = mode_q;
    out_sum_d   = out_sum_q;
    out_valid_d = in_valid;
    out_last_d  = last_beat;
    out_carry_d = last_beat & c[DIGIT_W];
    out_ovf_d   = last_beat & (c[DIGIT_W] ^ c[DIGIT_W-1]);
    if (in_valid) begin
      carry_d   = c[DIGIT_W];
      cnt_d     = (cnt_q == LAST_IDX) ? '0 : cnt_q + CNT_W'(1);
      out_sum_d = s;
      if (first_beat) begin
        mode_d = sub;
      end
    end
  end

`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
  // Non-zero accumulator across the digits of the current word
  always_comb begin
    nz_next    = (first_beat ? 1'b0 : nz_q) | (|s);
    nz_d       = in_valid ? nz_next : nz_q;
    out_zero_d = last_beat & ~nz_next;
  end

  // Zero-flag state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      nz_q       <= 1'b0;
      out_zero_q <= 1'b0;
    end else begin
      nz_q       <= nz_d;
      out_zero_q <= out_zero_d;
    end
  end

  assign out_zero = out_zero_q;
`endif

  // State and output registers; reset discards any partial word
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_carry_q <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      out_carry_q <= out_carry_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign out_carry = out_carry_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_serial_addsub_digit.sv
// Directed bench for serial_addsub_digit: a 4-bit x 2-digit instance and a 1-bit x 8-digit instance.
// Inputs driven on negedge, outputs sampled 1 time unit after posedge.
// Expected values are hand-computed per vector.
module tb_serial_addsub_digit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // 4-bit digit, 2-digit word instance
  logic       v4 = 1'b0, s4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ov4, ol4, oc4, oo4;
  logic [3:0] os4;
  // 1-bit digit, 8-digit word instance
  logic       v1 = 1'b0, s1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       ov1, ol1, oc1, oo1;
  logic [0:0] os1;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
  logic       oz4, oz1;
`endif

  serial_addsub_digit #(.DIGIT_W(4), .WORD_DIGITS(2)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .sub(s4), .a(a4), .b(b4),
    .out_valid(ov4), .out_sum(os4), .out_last(ol4), .out_carry(oc4), .out_ovf(oo4)
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    , .out_zero(oz4)
`endif
  );

  serial_addsub_digit #(.DIGIT_W(1), .WORD_DIGITS(8)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .sub(s1), .a(a1), .b(b1),
    .out_valid(ov1), .out_sum(os1), .out_last(ol1), .out_carry(oc1), .out_ovf(oo1)
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    , .out_zero(oz1)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // One clock: drive 4-bit instance inputs on negedge, return #1 after posedge
  task automatic step4(input logic v, input logic sb, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    v4 = v; s4 = sb; a4 = a; b4 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input logic v, input logic sb, input logic a, input logic b);
    @(negedge clk);
    v1 = v; s1 = sb; a1 = a; b1 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic exp4(input string tag, input logic v, input logic [3:0] sm,
                      input logic l, input logic c, input logic o);
    chk({tag, ".valid"}, 32'(ov4), 32'(v));
    if (v) chk({tag, ".sum"}, 32'(os4), 32'(sm));
    chk({tag, ".last"},  32'(ol4), 32'(l));
    chk({tag, ".carry"}, 32'(oc4), 32'(c));
    chk({tag, ".ovf"},   32'(oo4), 32'(o));
  endtask

  task automatic exp1(input string tag, input logic v, input logic sm,
                      input logic l, input logic c, input logic o);
    chk({tag, ".valid"}, 32'(ov1), 32'(v));
    if (v) chk({tag, ".sum"}, 32'(os1), 32'(sm));
    chk({tag, ".last"},  32'(ol1), 32'(l));
    chk({tag, ".carry"}, 32'(oc1), 32'(c));
    chk({tag, ".ovf"},   32'(oo1), 32'(o));
  endtask

  // Safety net against a stuck run
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] wa, wb;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    exp4("rst4", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("rst4.sum0", 32'(os4), 32'h0);
    exp1("rst1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst1.sum0", 32'(os1), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 0x7F + 0x01 -> 0x80, signed overflow
    step4(1, 0, 4'hF, 4'h1); exp4("add7f.d0", 1, 4'h0, 0, 0, 0);
    step4(1, 0, 4'h7, 4'h0); exp4("add7f.d1", 1, 4'h8, 1, 0, 1);
    // 0x05 - 0x07 -> 0xFE, borrow
    step4(1, 1, 4'h5, 4'h7); exp4("sub57.d0", 1, 4'hE, 0, 0, 0);
    step4(1, 0, 4'h0, 4'h0); exp4("sub57.d1", 1, 4'hF, 1, 0, 0);
    // 0x80 - 0x01 -> 0x7F, sub dropped on 2nd beat but mode held
    step4(1, 1, 4'h0, 4'h1); exp4("sub80.d0", 1, 4'hF, 0, 0, 0);
    step4(1, 0, 4'h8, 4'h0); exp4("sub80.d1", 1, 4'h7, 1, 1, 1);
    step4(0, 0, 4'h0, 4'h0); exp4("idle4",    0, 4'h0, 0, 0, 0);

    // 1-bit digits: 0xFF + 0x01 with a 3-cycle gap between bits 3 and 4
    wa = 8'hFF; wb = 8'h01;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        for (int g = 0; g < 3; g++) begin
          step1(0, 0, 1'b0, 1'b0);
          exp1("gap", 0, 1'b0, 0, 0, 0);
        end
      end
      step1(1, 0, wa[i], wb[i]);
      exp1($sformatf("ff01.b%0d", i), 1, 1'b0, i == 7, i == 7, 0);
    end
    // 0x01 + 0x01 back-to-back: carry must not leak from the previous word
    wa = 8'h01; wb = 8'h01;
    for (int i = 0; i < 8; i++) begin
      step1(1, 0, wa[i], wb[i]);
      exp1($sformatf("0101.b%0d", i), 1, (i == 1), i == 7, 0, 0);
    end
    step1(0, 0, 1'b0, 1'b0); exp1("idle1", 0, 1'b0, 0, 0, 0);

    // Reset mid-word, with in_valid held high during reset
    step4(1, 0, 4'hF, 4'hF); exp4("pre.d0", 1, 4'hE, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1; v4 = 1'b1; a4 = 4'h9; b4 = 4'h9;
    @(posedge clk); #1;
    exp4("inrst.a", 0, 4'h0, 0, 0, 0);
    chk("inrst.a.sum0", 32'(os4), 32'h0);
    @(posedge clk); #1;
    exp4("inrst.b", 0, 4'h0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0; v4 = 1'b0;
    // 0x12 + 0x34 -> 0x46
    step4(1, 0, 4'h2, 4'h4); exp4("p1234.d0", 1, 4'h6, 0, 0, 0);
    step4(1, 0, 4'h1, 4'h3); exp4("p1234.d1", 1, 4'h4, 1, 0, 0);
    step4(0, 0, 4'h0, 4'h0); exp4("idle4b",   0, 4'h0, 0, 0, 0);

`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    // 0x10 - 0x10 -> 0x00, zero, no borrow
    step4(1, 1, 4'h0, 4'h0); exp4("z1010.d0", 1, 4'h0, 0, 0, 0); chk("z1010.d0.zero", 32'(oz4), 32'h0);
    step4(1, 0, 4'h1, 4'h1); exp4("z1010.d1", 1, 4'h0, 1, 1, 0); chk("z1010.d1.zero", 32'(oz4), 32'h1);
    // 0x10 - 0x0F -> 0x01, not zero
    step4(1, 1, 4'h0, 4'hF); exp4("z100f.d0", 1, 4'h1, 0, 0, 0); chk("z100f.d0.zero", 32'(oz4), 32'h0);
    step4(1, 0, 4'h1, 4'h0); exp4("z100f.d1", 1, 4'h0, 1, 1, 0); chk("z100f.d1.zero", 32'(oz4), 32'h0);
    step4(0, 0, 4'h0, 4'h0); chk("zidle.zero", 32'(oz4), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_addsub_digit.md
Name: serial_addsub_digit

Overview:
- Parametrised digit-serial adder/subtractor. Processes two's-complement operands LSB-digit-first, DIGIT_W bits per accepted beat, WORD_DIGITS beats per word.
- Keeps the inter-digit carry and a digit position counter.
- Per-word mode select (add/sub), registered outputs, and end-of-word carry and signed-overflow flags.
- Sits between serialising shift registers and result deserialisers in the sequential arithmetic datapath.

Parameters:
- DIGIT_W, 1, bits processed per beat (>=1).
- WORD_DIGITS, 8, beats per operand word (>=1); word width = DIGIT_W*WORD_DIGITS.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  a/b/sub are valid this cycle; beat accepted. No backpressure.
- sub  input  1  mode, sampled only on the first beat of a word: 0 = a+b, 1 = a-b.
- a  input  DIGIT_W  operand A digit.
- b  input  DIGIT_W  operand B digit.
- out_valid  output  1  registered result digit valid.
- out_sum  output  DIGIT_W  result digit.
- out_last  output  1  out_valid beat is the final digit of the word.
- out_carry  output  1  word carry-out, valid when out_last=1; 0 otherwise. For sub, 1 = no borrow.
- out_ovf  output  1  signed overflow, valid when out_last=1; 0 otherwise.

Behaviour:
- State:
  - cnt: digit index, 0..WORD_DIGITS-1, $clog2 width with a minimum of 1 bit.
  - carry: 1 bit.
  - mode: latched sub.
- First beat (cnt==0):
  - Effective mode m = sub input.
  - Carry-in = sub.
  - mode <= sub.
- Other beats:
  - m = mode.
  - Carry-in = carry register.
- Digit datapath:
  - b_eff = b ^ {DIGIT_W{m}}.
  - Ripple chain of DIGIT_W full adders built only from ^ & | ~; no + or - operators.
  - s[i] = a[i]^b_eff[i]^c[i].
  - c[i+1] = a[i]&b_eff[i] | a[i]&c[i] | b_eff[i]&c[i].
  - c[0] = carry-in.
- On an accepted beat:
  - carry <= c[DIGIT_W].
  - cnt <= (cnt==WORD_DIGITS-1) ? 0 : cnt+1.
- Outputs, registered with 1-cycle latency:
  - out_valid <= in_valid.
  - out_sum <= s.
  - out_last <= in_valid & (cnt==WORD_DIGITS-1).
  - out_carry <= that last term & c[DIGIT_W].
  - out_ovf <= that last term & (c[DIGIT_W] ^ c[DIGIT_W-1]).
- in_valid=0:
  - cnt, carry and mode hold.
  - out_valid and out_last go to 0 next cycle.
  - out_sum holds its previous value; don't-care for checking.
  - Gaps are allowed anywhere inside a word.
- Word boundary: after the last beat, the next accepted beat is a first beat, so the carry does not leak between words. Back-to-back words run at full rate, no dead cycle.
- WORD_DIGITS=1: every beat is both first and last; out_last equals out_valid.
- Reset: cnt=0, carry=0, mode=0, out_valid=0, out_sum=0, out_last=0, out_carry=0, out_ovf=0 (plus out_zero=0 when the optional feature is enabled). Reset mid-word discards the partial word; the first beat after reset is a first beat.
- rst has priority over in_valid in the same cycle.

Optional Feature:
- Macro SERIAL_ADDSUB_ZERO_FLAG_EN.
- Defined:
  - Adds output port out_zero (1 bit) and an internal nz accumulator.
  - nz is cleared on the first beat; nz <= nz | (|s) on each accepted beat.
  - out_zero <= last_beat & ~(nz_next), i.e. the whole result word is 0.
  - out_zero is 0 on non-last beats and on reset.
- Undefined: no out_zero port, no accumulator; all other behaviour is identical.

Test Plan:
- DIGIT_W=4, WORD_DIGITS=2, add 0x7F+0x01: beats (a,b)=(F,1),(7,0) -> out_sum 0x0 then 0x8, out_last on 2nd, out_carry=0, out_ovf=1.
- Same config, sub 0x05-0x07: beats (5,7),(0,0) with sub=1 on first beat only -> sums 0xE,0xF (0xFE), out_carry=0 (borrow), out_ovf=0.
- Sub 0x80-0x01 with sub driven to 0 on the 2nd beat -> mode latched; result 0x7F, out_carry=1, out_ovf=1.
- DIGIT_W=1, WORD_DIGITS=8, 0xFF+0x01 with in_valid low 3 cycles between bits 3 and 4 -> 8 out_valid beats all 0, out_carry=1 on the last; then 0x01+0x01 back-to-back -> 0x02, proving carry cleared at the word boundary.
- Assert rst after 1 beat of a 2-digit word, then send 0x12+0x34 -> all outputs 0 during and after reset, then result 0x46 with correct framing.
- With SERIAL_ADDSUB_ZERO_FLAG_EN defined: 0x10-0x10 -> out_zero=1, out_carry=1; 0x10-0x0F -> out_zero=0.
